// File: rtl/mulb_ctrl_pkg.sv
// rtl/mulb_ctrl_pkg.sv - shared types and widths for the baseline multiply sequencer
package mulb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } mulb_state_e;

  localparam int PERF_W = 32;

endpackage

// File: rtl/mulb_valid_pipe.sv
// rtl/mulb_valid_pipe.sv - two-stage valid/last tracker for input and product registers
module mulb_valid_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic adv_i,
  input  logic load_i,
  input  logic last_i,
  output logic v1_o,
  output logic v2_o,
  output logic l1_o,
  output logic l2_o
);

  logic v1_q, v2_q, l1_q, l2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else if (adv_i) begin
      v2_q <= v1_q;
      l2_q <= l1_q;
      v1_q <= load_i;
      l1_q <= load_i && last_i;
    end
  end

  assign v1_o = v1_q;
  assign v2_o = v2_q;
  assign l1_o = l1_q;
  assign l2_o = l2_q;

endmodule

// File: rtl/mul_baseline_ctrl.sv
// rtl/mul_baseline_ctrl.sv - sequencer for in_reg -> weight x input -> out_reg datapath
// Optional performance counters are built only when MULB_PERF_CNT_EN is defined.
module mul_baseline_ctrl
  import mulb_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              in_reg_en,
  output logic              weight_reg_en,
  output logic              prod_reg_en,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  batch_cnt,
  output logic [PERF_W-1:0] perf_busy_cyc,
  output logic [PERF_W-1:0] perf_stall_cyc
);

  mulb_state_e state_q, state_d;
  logic v1, v2, l1, l2;
  logic adv, in_hs, out_hs;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic last_done_q;

  assign adv    = !(v2 && !out_ready);
  assign in_hs  = in_valid && in_ready;
  assign out_hs = v2 && out_ready;

  mulb_valid_pipe u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (adv),
    .load_i (in_hs),
    .last_i (in_last),
    .v1_o   (v1),
    .v2_o   (v2),
    .l1_o   (l1),
    .l2_o   (l2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Weight is only taken once the input stage is empty so in-flight products keep a stable operand.
  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = !v1;
        if (w_valid && !v1) state_d = STREAM;
      end
      STREAM: begin
        in_ready = adv;
        if (in_valid && adv && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!v1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_reg_en     = in_hs;
  assign prod_reg_en   = adv && v1;
  assign weight_reg_en = w_valid && w_ready;
  assign out_valid     = v2;
  assign out_last      = l2;
  assign busy          = (state_q != IDLE) || v1 || v2;

  // The count of a finished batch stays visible for one cycle before clearing.
  always_comb begin
    cnt_base = last_done_q ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (out_hs && (cnt_base != {CNT_W{1'b1}})) cnt_d = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_done_q <= out_hs && l2;
    end
  end

  assign batch_cnt = cnt_q;

`ifdef MULB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy)             perf_busy_q  <= perf_busy_q + PERF_W'(1);
      if (v2 && !out_ready) perf_stall_q <= perf_stall_q + PERF_W'(1);
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`else
  assign perf_busy_cyc  = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mul_baseline_ctrl.sv
// tb/tb_mul_baseline_ctrl.sv - scoreboard bench for mul_baseline_ctrl with a scalar model datapath
module tb_mul_baseline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_valid = 1'b0, w_ready;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic        in_reg_en, weight_reg_en, prod_reg_en;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [15:0] batch_cnt;
  logic [31:0] perf_busy_cyc, perf_stall_cyc;

  logic [7:0]  w_data = 8'd0, in_data = 8'd0;
  logic [7:0]  w_reg, in_reg;
  logic [15:0] prod_reg;

  typedef struct {
    logic [15:0] prod;
    logic        last;
    int          edge_exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   chk_lat = 0;
  int   w_hs_edge = 0;
  int   in_hs_edge = 0;
  logic [7:0] cur_w = 8'd0;

  mul_baseline_ctrl #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .in_reg_en      (in_reg_en),
    .weight_reg_en  (weight_reg_en),
    .prod_reg_en    (prod_reg_en),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .batch_cnt      (batch_cnt),
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (weight_reg_en) w_reg <= w_data;
    if (in_reg_en)     in_reg <= in_data;
    if (prod_reg_en)   prod_reg <= w_reg * in_reg;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out act=%0d exp=none", prod_reg);
      end else begin
        e = sb_q.pop_front();
        check("prod", prod_reg, e.prod);
        check("out_last", out_last, e.last);
        if (e.edge_exp >= 0) check("latency", cyc + 1, e.edge_exp);
      end
    end
    if (rst_n && out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
  end

  task automatic send_w(input logic [7:0] w);
    int n = 0;
    w_valid = 1'b1;
    w_data  = w;
    #1;
    while (!w_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w_accept_in_time", n < 50, 1);
    cur_w = w;
    w_hs_edge = cyc + 1;
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_in(input logic [7:0] d, input logic last);
    int n = 0;
    logic [15:0] p;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("in_accept_in_time", n < 50, 1);
    p = cur_w * d;
    sb_q.push_back('{prod: p, last: last, edge_exp: (chk_lat != 0) ? cyc + 3 : -1});
    in_hs_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while ((busy || out_valid) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_in_time", n < 100, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    int t;
    logic [31:0] pb0, ps0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_w_ready", w_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_batch_cnt", batch_cnt, 0);
    check("rst_prod_en", prod_reg_en, 0);
    check("rst_perf_busy", perf_busy_cyc, 0);
    check("rst_perf_stall", perf_stall_cyc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // batch of 4, out_ready held high
    chk_lat = 1;
    send_w(8'd3);
    send_in(8'd1, 1'b0);
    t0 = in_hs_edge;
    check("b4_first_in_edge", t0, w_hs_edge + 1);
    send_in(8'd2, 1'b0);
    send_in(8'd4, 1'b0);
    send_in(8'd9, 1'b1);
    while (cyc <= t0 + 6) begin
      #1;
      k = cyc;
      check("b4_batch_cnt", batch_cnt, (k >= t0 + 6) ? 0 : (k - (t0 + 1)));
      @(negedge clk);
    end
    chk_lat = 0;
    wait_idle();

    // batch of 5 with 3 stall cycles
    send_w(8'd7);
    fork
      begin
        send_in(8'd2, 1'b0);
        send_in(8'd3, 1'b0);
        send_in(8'd4, 1'b0);
        send_in(8'd5, 1'b0);
        send_in(8'd6, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_sb_drained", sb_q.size(), 0);

    // single-vector batch
    chk_lat = 1;
    send_w(8'd11);
    send_in(8'd5, 1'b1);
    t = in_hs_edge;
    #1;
    check("sv_w_ready_t", w_ready, 0);
    @(negedge clk);
    #1;
    check("sv_w_ready_t1", w_ready, 0);
    @(negedge clk);
    #1;
    check("sv_w_ready_t2", w_ready, 1);
    check("sv_edge_ref", cyc, t + 2);
    chk_lat = 0;
    wait_idle();

    // input held during IDLE before the weight
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b0;
    repeat (3) begin
      #1;
      check("idle_no_in_load", in_reg_en, 0);
      @(negedge clk);
    end
    send_w(8'd4);
    #1;
    check("idle_first_in_load", in_reg_en, 1);
    send_in(8'd9, 1'b0);
    check("idle_first_in_edge", in_hs_edge, w_hs_edge + 1);
    send_in(8'd10, 1'b1);
    wait_idle();

    // performance counters: batch of 4 with 2 stall cycles on the last result
    pb0 = perf_busy_cyc;
    ps0 = perf_stall_cyc;
    send_w(8'd5);
    send_in(8'd1, 1'b0);
    send_in(8'd2, 1'b0);
    send_in(8'd3, 1'b0);
    send_in(8'd4, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
`ifdef MULB_PERF_CNT_EN
    check("perf_busy_delta", perf_busy_cyc - pb0, 8);
    check("perf_stall_delta", perf_stall_cyc - ps0, 2);
`else
    check("perf_busy_zero", perf_busy_cyc, 0);
    check("perf_stall_zero", perf_stall_cyc, 0);
`endif

    // asynchronous reset mid-stream with both stages full
    send_w(8'd2);
    send_in(8'd1, 1'b0);
    send_in(8'd2, 1'b0);
    #1;
    check("mid_pre_v2", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_w_ready", w_ready, 1);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_batch_cnt", batch_cnt, 0);
    check("mid_rst_prod_en", prod_reg_en, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_w(8'd6);
    send_in(8'd7, 1'b1);
    wait_idle();
    check("final_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
